event_builder_rr: RTL

- Parametrised successor to the single-path digital_core event capture.
- Collects per-channel SAR ADC conversion results and tags each with chip ID, channel ID and a free-running timestamp.
- Arbitrates across channels round-robin and packs each result into a WIDTH-bit odd-parity data packet.
- Buffers packets in an internal FIFO that drains through a valid/ready handshake to the UART TX path.

---
 rtl/event_builder_pkg.sv | 35 +++
 rtl/event_builder_rr_fifo.sv | 75 +++++++
 rtl/event_builder_rr.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/event_builder_pkg.sv
// Shared constants and helpers for the event builder: packet field layout
// and the parity function used to seal each packet.
package event_builder_pkg;

  // Data packets carry this code in their two least significant bits.
  localparam logic [1:0] PKT_TYPE_DATA = 2'b01;
  localparam int         PKT_TYPE_W    = 2;

  // Widest packet the parity helper accepts; callers zero-extend into it,
  // which leaves the XOR reduction unchanged.
  localparam int         PKT_MAX_W     = 256;

  // Field offsets, LSB first: type, chip ID, channel ID, timestamp, ADC.
  function automatic int pkt_chip_off();
    return PKT_TYPE_W;
  endfunction

  function automatic int pkt_chan_off(input int chip_w);
    return PKT_TYPE_W + chip_w;
  endfunction

  function automatic int pkt_ts_off(input int chip_w, input int chan_w);
    return PKT_TYPE_W + chip_w + chan_w;
  endfunction

  function automatic int pkt_adc_off(input int chip_w, input int chan_w, input int ts_w);
    return PKT_TYPE_W + chip_w + chan_w + ts_w;
  endfunction

  // Odd parity: the returned bit makes the total number of ones odd.
  function automatic logic odd_parity(input logic [PKT_MAX_W-1:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/event_builder_rr_fifo.sv
// Synchronous FIFO holding finished packets until the consumer takes them.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH      = 54,
  parameter int FIFO_DEPTH = 64,
  parameter int FIFO_BITS  = 6
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     data_o,
  output logic [FIFO_BITS:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_BITS:0]   count_q, count_d;
  logic                 do_push_s;
  logic                 do_pop_s;

  assign full_o  = (count_q == (FIFO_BITS+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    do_pop_s  = pop_i && !empty_o;
    do_push_s = push_i && (!full_o || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + FIFO_BITS'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + FIFO_BITS'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (FIFO_BITS+1)'(1);
      2'b01:   count_d = count_q - (FIFO_BITS+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage; contents are meaningless while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/event_builder_rr.sv
// Event builder: captures per-channel ADC results with a timestamp, picks
// one pending channel per cycle round-robin, packs it into an odd-parity
// packet and queues it for the UART transmitter.
module event_builder_rr
  import event_builder_pkg::*;
#(
  parameter int NUMCHANNELS  = 32,
  parameter int ADCBITS      = 6,
  parameter int CHIP_ID_W    = 8,
  parameter int CHANNEL_ID_W = 7,
  parameter int TIME_STAMP_W = 24,
  parameter int WIDTH        = 54,
  parameter int FIFO_DEPTH   = 64,
  parameter int FIFO_BITS    = 6,
  parameter int LOST_W       = 16
) (
  input  logic                           clk4x,
  input  logic                           reset,
  input  logic [CHIP_ID_W-1:0]           chip_id,
  input  logic [NUMCHANNELS-1:0]         adc_done,
  input  logic [NUMCHANNELS*ADCBITS-1:0] adc_word,
  input  logic                           ts_clear,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [FIFO_BITS:0]             fifo_count,
  output logic                           fifo_full,
  output logic                           fifo_half,
  output logic [NUMCHANNELS-1:0]         pending,
  output logic [LOST_W-1:0]              lost_count
);

  localparam int OFF_CHIP = pkt_chip_off();
  localparam int OFF_CHAN = pkt_chan_off(CHIP_ID_W);
  localparam int OFF_TS   = pkt_ts_off(CHIP_ID_W, CHANNEL_ID_W);
  localparam int OFF_ADC  = pkt_adc_off(CHIP_ID_W, CHANNEL_ID_W, TIME_STAMP_W);
  localparam int LOSS_W   = $clog2(NUMCHANNELS + 1);
  localparam int SUM_W    = LOST_W + LOSS_W;
  localparam int CHW1     = CHANNEL_ID_W + 1;
  localparam logic [CHW1-1:0] LAST_CH = CHW1'(NUMCHANNELS - 1);

  logic [TIME_STAMP_W-1:0] ts_q, ts_d;
  logic [NUMCHANNELS-1:0]  pending_q, pending_d;
  logic [ADCBITS-1:0]      slot_adc_q [NUMCHANNELS];
  logic [TIME_STAMP_W-1:0] slot_ts_q  [NUMCHANNELS];
  logic [NUMCHANNELS-1:0]  cap_vec_s, loss_vec_s;
  logic [NUMCHANNELS-1:0]  rr_mask_s, rr_req_s, gnt_onehot_s;
  logic [CHANNEL_ID_W-1:0] rr_ptr_q, rr_ptr_d, gnt_idx_s;
  logic                    grant_s, write_ok_s;
  logic [LOST_W-1:0]       lost_q, lost_d;
  logic [LOSS_W-1:0]       loss_num_s;
  logic [SUM_W-1:0]        lost_sum_s;
  logic [ADCBITS-1:0]      sel_adc_s;
  logic [TIME_STAMP_W-1:0] sel_ts_s;
  logic [WIDTH-2:0]        pkt_body_s;
  logic [WIDTH-1:0]        pkt_s;
  logic                    fifo_empty_s;

  // Free-running timestamp; ts_clear restarts it from zero.
  always_comb begin
    if (ts_clear) begin
      ts_d = '0;
    end else begin
      ts_d = ts_q + TIME_STAMP_W'(1);
    end
  end

  // Round-robin pick: lowest pending channel at or above the pointer,
  // otherwise wrap to the lowest pending channel overall.
  always_comb begin
    rr_mask_s    = '0;
    rr_req_s     = '0;
    gnt_idx_s    = '0;
    gnt_onehot_s = '0;
    for (int i = 0; i < NUMCHANNELS; i++) begin
      if (CHANNEL_ID_W'(i) >= rr_ptr_q) begin
        rr_mask_s[i] = 1'b1;
      end else begin
        rr_mask_s[i] = 1'b0;
      end
    end
    if (|(pending_q & rr_mask_s)) begin
      rr_req_s = pending_q & rr_mask_s;
    end else begin
      rr_req_s = pending_q;
    end
    for (int i = NUMCHANNELS - 1; i >= 0; i--) begin
      if (rr_req_s[i]) begin
        gnt_idx_s = CHANNEL_ID_W'(i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
    write_ok_s = !fifo_full || (out_valid && out_ready);
    grant_s    = (|pending_q) && write_ok_s;
    for (int i = 0; i < NUMCHANNELS; i++) begin
      if (grant_s && (gnt_idx_s == CHANNEL_ID_W'(i))) begin
        gnt_onehot_s[i] = 1'b1;
      end else begin
        gnt_onehot_s[i] = 1'b0;
      end
    end
  end

  // Next search start is the channel after the one just granted.
  always_comb begin
    if (!grant_s) begin
      rr_ptr_d = rr_ptr_q;
    end else if ({1'b0, gnt_idx_s} == LAST_CH) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = gnt_idx_s + CHANNEL_ID_W'(1);
    end
  end

  // Per-channel capture/discard decision; a grant frees the slot in the
  // same edge, so a result arriving then is kept rather than lost.
  always_comb begin
    pending_d  = pending_q;
    cap_vec_s  = '0;
    loss_vec_s = '0;
    for (int i = 0; i < NUMCHANNELS; i++) begin
      if (adc_done[i]) begin
        if (!pending_q[i] || gnt_onehot_s[i]) begin
          cap_vec_s[i] = 1'b1;
          pending_d[i] = 1'b1;
        end else begin
          loss_vec_s[i] = 1'b1;
          pending_d[i]  = 1'b1;
        end
      end else if (gnt_onehot_s[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // Add all of this edge's discarded results, saturating at all-ones.
  always_comb begin
    loss_num_s = '0;
    for (int i = 0; i < NUMCHANNELS; i++) begin
      loss_num_s = loss_num_s + LOSS_W'(loss_vec_s[i]);
    end
    lost_sum_s = SUM_W'(lost_q) + SUM_W'(loss_num_s);
    if (lost_sum_s > SUM_W'({LOST_W{1'b1}})) begin
      lost_d = '1;
    end else begin
      lost_d = lost_sum_s[LOST_W-1:0];
    end
  end

  // Assemble the packet for the granted slot and seal it with parity.
  always_comb begin
    sel_adc_s = '0;
    sel_ts_s  = '0;
    for (int i = 0; i < NUMCHANNELS; i++) begin
      sel_adc_s = sel_adc_s | (slot_adc_q[i] & {ADCBITS{gnt_onehot_s[i]}});
      sel_ts_s  = sel_ts_s  | (slot_ts_q[i]  & {TIME_STAMP_W{gnt_onehot_s[i]}});
    end
    pkt_body_s                            = '0;
    pkt_body_s[PKT_TYPE_W-1:0]            = PKT_TYPE_DATA;
    pkt_body_s[OFF_CHIP +: CHIP_ID_W]     = chip_id;
    pkt_body_s[OFF_CHAN +: CHANNEL_ID_W]  = gnt_idx_s;
    pkt_body_s[OFF_TS   +: TIME_STAMP_W]  = sel_ts_s;
    pkt_body_s[OFF_ADC  +: ADCBITS]       = sel_adc_s;
    pkt_s = {odd_parity(PKT_MAX_W'(pkt_body_s)), pkt_body_s};
  end

  // Timestamp, arbiter pointer, pending flags and loss counter.
  always_ff @(posedge clk4x) begin
    if (reset) begin
      ts_q      <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
      lost_q    <= '0;
    end else begin
      ts_q      <= ts_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
    end
  end

  // Capture slots: result and timestamp of the oldest unsent conversion.
  always_ff @(posedge clk4x) begin
    if (reset) begin
      for (int i = 0; i < NUMCHANNELS; i++) begin
        slot_adc_q[i] <= '0;
        slot_ts_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUMCHANNELS; i++) begin
        if (cap_vec_s[i]) begin
          slot_adc_q[i] <= adc_word[i*ADCBITS +: ADCBITS];
          slot_ts_q[i]  <= ts_q;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_BITS  (FIFO_BITS)
  ) u_fifo (
    .clk_i   (clk4x),
    .reset_i (reset),
    .push_i  (grant_s),
    .data_i  (pkt_s),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty_s)
  );

  assign out_valid  = !fifo_empty_s;
  assign fifo_half  = (fifo_count >= (FIFO_BITS+1)'(FIFO_DEPTH / 2));
  assign pending    = pending_q;
  assign lost_count = lost_q;

endmodule
